// File: rtl/acc_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode encoding and FSM states.
package acc_cpu_pkg;

   typedef enum logic [2:0] {
      OpLda = 3'b000,
      OpSta = 3'b001,
      OpAdd = 3'b010,
      OpSub = 3'b011,
      OpJmp = 3'b100,
      OpJz  = 3'b101,
      OpJc  = 3'b110,
      OpHlt = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      StHalt,
      StFetch,
      StDecode,
      StMem
   } state_t;

endpackage

// File: rtl/acc_cpu_if.sv
// Single-port memory bus between the core (master) and memory (slave).
interface acc_cpu_if #(
   parameter int unsigned DW = 8
);
   localparam int unsigned AW = DW - 3;

   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;

   modport master (
      output mem_req, mem_we, mem_adr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_adr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/acc_cpu_alu.sv
// Accumulator datapath: pass-through for LDA, add/sub with carry-out, zero detect.
module acc_cpu_alu
   import acc_cpu_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  opcode_t       op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic [DW-1:0] result,
   output logic          carry,
   output logic          zero
);

   logic [DW:0] sum;

   // For SUB the extended top bit is the borrow, i.e. a < b unsigned.
   always_comb begin
      sum = {1'b0, b};
      case (op)
         OpAdd:   sum = {1'b0, a} + {1'b0, b};
         OpSub:   sum = {1'b0, a} - {1'b0, b};
         default: sum = {1'b0, b};
      endcase
   end

   assign result = sum[DW-1:0];
   assign carry  = sum[DW];
   assign zero   = (sum[DW-1:0] == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU: HALT/FETCH/DECODE/MEM sequencer plus PC, IR, AC and flags.
module acc_cpu_core
   import acc_cpu_pkg::*;
#(
   parameter int unsigned DW = 8
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      start,
   acc_cpu_if.master bus,
   output logic      halted,
   output logic      flag_z,
   output logic      flag_c
);

   localparam int unsigned AW = DW - 3;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [DW-1:0] ir_q, ir_d;
   logic [DW-1:0] ac_q, ac_d;
   logic          z_q, z_d;
   logic          c_q, c_d;

   opcode_t       opcode;
   logic [AW-1:0] addr;
   logic [DW-1:0] alu_result;
   logic          alu_carry;
   logic          alu_zero;

   assign opcode = opcode_t'(ir_q[DW-1:AW]);
   assign addr   = ir_q[AW-1:0];

   acc_cpu_alu #(
      .DW (DW)
   ) u_alu (
      .op     (opcode),
      .a      (ac_q),
      .b      (bus.mem_rdata),
      .result (alu_result),
      .carry  (alu_carry),
      .zero   (alu_zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StHalt;
         pc_q    <= '0;
         ir_q    <= '0;
         ac_q    <= '0;
         z_q     <= 1'b0;
         c_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         ac_q    <= ac_d;
         z_q     <= z_d;
         c_q     <= c_d;
      end
   end

   // Bus outputs derive only from registered state, so they hold steady across wait cycles.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ir_d        = ir_q;
      ac_d        = ac_q;
      z_d         = z_q;
      c_d         = c_q;
      bus.mem_req = 1'b0;
      bus.mem_we  = 1'b0;
      bus.mem_adr = '0;

      case (state_q)
         StHalt: begin
            if (start) begin
               pc_d    = '0;
               state_d = StFetch;
            end
         end
         StFetch: begin
            bus.mem_req = 1'b1;
            bus.mem_adr = pc_q;
            if (bus.mem_ack) begin
               ir_d    = bus.mem_rdata;
               pc_d    = pc_q + AW'(1);
               state_d = StDecode;
            end
         end
         StDecode: begin
            case (opcode)
               OpJmp: begin
                  pc_d    = addr;
                  state_d = StFetch;
               end
               OpJz: begin
                  if (z_q) pc_d = addr;
                  state_d = StFetch;
               end
               OpJc: begin
                  if (c_q) pc_d = addr;
                  state_d = StFetch;
               end
               OpHlt:   state_d = StHalt;
               default: state_d = StMem;
            endcase
         end
         StMem: begin
            bus.mem_req = 1'b1;
            bus.mem_adr = addr;
            bus.mem_we  = (opcode == OpSta);
            if (bus.mem_ack) begin
               if (opcode != OpSta) begin
                  ac_d = alu_result;
                  z_d  = alu_zero;
                  if (opcode == OpAdd || opcode == OpSub) c_d = alu_carry;
               end
               state_d = StFetch;
            end
         end
         default: state_d = StHalt;
      endcase
   end

   assign bus.mem_wdata = ac_q;
   assign halted        = (state_q == StHalt);
   assign flag_z        = z_q;
   assign flag_c        = c_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Directed bench for acc_cpu_core (DW=8): small programs against a bus memory model.
module tb_acc_cpu_core;
   import acc_cpu_pkg::*;

   logic clk;
   logic rst_n;
   logic start;
   logic halted;
   logic flag_z;
   logic flag_c;

   int checks;
   int failures;

   logic [7:0] mem [32];
   int         xlog [$];
   int         wait_mode;  // 0 zero-wait, 1 random 0..3, 2 fixed 3
   logic       noise_ack;
   logic       in_xfer;
   int         wait_left;
   logic [4:0] held_adr;
   logic       held_we;
   int         cyc;
   logic       seen_we;

   acc_cpu_if #(.DW(8)) bus ();

   assign bus.mem_rdata = mem[bus.mem_adr];

   acc_cpu_core #(
      .DW (8)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .bus    (bus),
      .halted (halted),
      .flag_z (flag_z),
      .flag_c (flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Memory model acts at the falling edge; ack applies to the next rising edge.
   task automatic service();
      if (bus.mem_req) begin
         if (!in_xfer) begin
            in_xfer   = 1'b1;
            held_adr  = bus.mem_adr;
            held_we   = bus.mem_we;
            wait_left = (wait_mode == 1) ? int'($urandom_range(0, 3)) :
                        (wait_mode == 2) ? 3 : 0;
         end else begin
            check("stable_adr", {27'd0, bus.mem_adr}, {27'd0, held_adr});
            check("stable_we", {31'd0, bus.mem_we}, {31'd0, held_we});
         end
         if (wait_left == 0) begin
            bus.mem_ack = 1'b1;
            if (bus.mem_we) mem[bus.mem_adr] = bus.mem_wdata;
            xlog.push_back(int'(bus.mem_adr));
            in_xfer = 1'b0;
         end else begin
            bus.mem_ack = 1'b0;
            wait_left--;
         end
      end else begin
         bus.mem_ack = noise_ack;
         in_xfer     = 1'b0;
      end
   endtask

   task automatic step();
      @(negedge clk);
      service();
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic run_until_halt(input int budget, output int cycles);
      cycles = 0;
      while (!halted && cycles < budget) begin
         step();
         cycles++;
      end
      check("halt_reached", {31'd0, halted}, 32'd1);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 32; i++) mem[i] = 8'h00;
      xlog.delete();
   endtask

   task automatic load_add_prog();
      clear_mem();
      mem[0]  = 8'h0A;  // LDA 10
      mem[1]  = 8'h4B;  // ADD 11
      mem[2]  = 8'h2C;  // STA 12
      mem[3]  = 8'hE0;  // HLT
      mem[10] = 8'h7F;
      mem[11] = 8'h01;
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      wait_mode   = 0;
      noise_ack   = 1'b0;
      in_xfer     = 1'b0;
      wait_left   = 0;
      held_adr    = '0;
      held_we     = 1'b0;
      seen_we     = 1'b0;
      start       = 1'b0;
      rst_n       = 1'b0;
      bus.mem_ack = 1'b0;
      clear_mem();

      #1;
      check("rst_halted", {31'd0, halted}, 32'd1);
      check("rst_req", {31'd0, bus.mem_req}, 32'd0);
      check("rst_adr", {27'd0, bus.mem_adr}, 32'd0);
      check("rst_ac", {24'd0, bus.mem_wdata}, 32'd0);
      check("rst_flags", {30'd0, flag_c, flag_z}, 32'd0);

      // Idle after reset release, stray acks ignored
      step();
      step();
      rst_n     = 1'b1;
      noise_ack = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("idle_after_rst", {31'd0, halted}, 32'd1);
      check("idle_no_req", {31'd0, bus.mem_req}, 32'd0);
      noise_ack = 1'b0;
      step();

      // LDA/ADD/STA/HLT, zero wait
      load_add_prog();
      pulse_start();
      run_until_halt(50, cyc);
      check("p1_cycles", cyc, 32'd11);
      check("p1_mem12", {24'd0, mem[12]}, 32'h80);
      check("p1_ac", {24'd0, bus.mem_wdata}, 32'h80);
      check("p1_flags", {30'd0, flag_c, flag_z}, 32'd0);
      check("p1_xfers", xlog.size(), 32'd7);

      // ADD overflow then taken JC
      clear_mem();
      mem[0]  = 8'h0A;  // LDA 10
      mem[1]  = 8'h4B;  // ADD 11
      mem[2]  = 8'hD4;  // JC 20
      mem[20] = 8'hE0;  // HLT
      mem[10] = 8'hFF;
      mem[11] = 8'h01;
      pulse_start();
      run_until_halt(50, cyc);
      check("p2_cycles", cyc, 32'd10);
      check("p2_ac", {24'd0, bus.mem_wdata}, 32'h00);
      check("p2_flags_cz", {30'd0, flag_c, flag_z}, 32'd3);
      check("p2_jc_target", xlog[5], 32'd20);

      // SUB borrow then untaken JZ
      clear_mem();
      mem[0]  = 8'h0A;  // LDA 10
      mem[1]  = 8'h6B;  // SUB 11
      mem[2]  = 8'hA7;  // JZ 7
      mem[3]  = 8'hE0;  // HLT
      mem[7]  = 8'h0A;
      mem[10] = 8'h03;
      mem[11] = 8'h05;
      pulse_start();
      run_until_halt(50, cyc);
      check("p3_ac", {24'd0, bus.mem_wdata}, 32'hFE);
      check("p3_flags_cz", {30'd0, flag_c, flag_z}, 32'd2);
      check("p3_jz_fallthru", xlog[5], 32'd3);

      // Non-jump at 31 wraps PC to 0; STA at 31 plants HLT at 0
      clear_mem();
      mem[0]  = 8'h9E;  // JMP 30
      mem[30] = 8'h0A;  // LDA 10
      mem[31] = 8'h20;  // STA 0
      mem[10] = 8'hE0;
      pulse_start();
      run_until_halt(50, cyc);
      check("p4_cycles", cyc, 32'd10);
      check("p4_wrap_fetch", xlog[5], 32'd0);
      check("p4_mem0", {24'd0, mem[0]}, 32'hE0);

      // JMP 31 at 31 loops on itself
      clear_mem();
      mem[0]  = 8'h9F;
      mem[31] = 8'h9F;
      pulse_start();
      for (int i = 0; i < 7; i++) step();
      check("p5_loop1", xlog[1], 32'd31);
      check("p5_loop3", xlog[3], 32'd31);
      check("p5_running", {31'd0, halted}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("p5_async_rst", {31'd0, halted}, 32'd1);
      step();
      rst_n = 1'b1;
      step();

      // Random wait states plus an ignored mid-run start
      load_add_prog();
      wait_mode = 1;
      pulse_start();
      for (int i = 0; i < 4; i++) step();
      pulse_start();
      run_until_halt(200, cyc);
      check("p6_mem12", {24'd0, mem[12]}, 32'h80);
      check("p6_ac", {24'd0, bus.mem_wdata}, 32'h80);
      check("p6_xfers", xlog.size(), 32'd7);
      check("p6_sta_adr", xlog[5], 32'd12);

      // Reset during a waiting STA
      clear_mem();
      mem[0]  = 8'h0A;  // LDA 10
      mem[1]  = 8'h2C;  // STA 12
      mem[2]  = 8'hE0;  // HLT
      mem[10] = 8'h33;
      mem[12] = 8'h55;
      wait_mode = 2;
      pulse_start();
      seen_we = 1'b0;
      for (int i = 0; i < 40 && !seen_we; i++) begin
         step();
         seen_we = bus.mem_req & bus.mem_we;
      end
      check("p7_write_pending", {31'd0, seen_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("p7_req", {31'd0, bus.mem_req}, 32'd0);
      check("p7_we", {31'd0, bus.mem_we}, 32'd0);
      check("p7_adr", {27'd0, bus.mem_adr}, 32'd0);
      check("p7_halted", {31'd0, halted}, 32'd1);
      check("p7_ac", {24'd0, bus.mem_wdata}, 32'd0);
      step();
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      check("p7_idle", {31'd0, halted}, 32'd1);
      check("p7_mem12", {24'd0, mem[12]}, 32'h55);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
